piece_randomizer: RTL and testbench

PIECE_RANDOMIZER -- requirements
Module: piece_randomizer

---
 rtl/piece_randomizer.sv | 222 ++++++++++++++++++++++
 tb/tb_piece_randomizer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_randomizer.sv
// piece_randomizer
// Generates a stream of piece IDs (0..NUM_PIECES-1) from a 16-bit Fibonacci
// LFSR. The low three LFSR bits are the candidate. Each draw tries at most
// MAX_TRIES+1 candidates. If none is acceptable, a deterministic fallback ID
// is issued, so the worst-case draw latency is bounded.
//
// Optional feature: define PIECE_RANDOMIZER_BAG_EN for "bag" mode. In bag
// mode every run of NUM_PIECES consecutive issues is a permutation of all IDs.
// Without the macro there is no bag logic, and bag_mask stays at zero.
//
// Handshake: piece/piece_valid act as a valid/ready pair, with next_req as
// ready. A piece is delivered in a cycle where piece_valid && next_req. The
// next cycle piece_valid drops and a new draw starts. piece and piece_valid
// hold steady until delivery. next_req is ignored while piece_valid is low;
// it is neither remembered nor queued.
//
// Debug outputs: o_dbg_state shows the FSM state and o_dbg_lfsr shows the
// live LFSR register.
module piece_randomizer #(
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] SEED       = 16'hACE1,
    parameter int                NUM_PIECES = 7,
    parameter int                STEP_MODE  = 0,
    parameter int                MAX_TRIES  = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed,
    input  logic                  next_req,
    output logic [2:0]            piece,
    output logic                  piece_valid,
    output logic [NUM_PIECES-1:0] bag_mask,
    output logic                  o_dbg_state,
    output logic [LFSR_W-1:0]     o_dbg_lfsr
);

    typedef enum logic {
        S_DRAW = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int                    TRY_W     = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;
    localparam logic [TRY_W-1:0]      TRY_MAX   = TRY_W'(MAX_TRIES);
    localparam logic [3:0]            NP4       = 4'(NUM_PIECES);
    localparam logic [NUM_PIECES-1:0] FULL_MASK = '1;

    // State and datapath registers
    state_t                r_state;
    logic [LFSR_W-1:0]     r_lfsr;
    logic                  r_frame_d;
    logic [TRY_W-1:0]      r_tries;
    logic [2:0]            r_piece;
    logic                  r_valid;
    logic [NUM_PIECES-1:0] r_bag_mask;

    // Combinational next values and helpers
    state_t                w_state_nxt;
    logic [LFSR_W-1:0]     w_lfsr_nxt;
    logic [LFSR_W-1:0]     w_lfsr_step;
    logic                  w_frame_edge;
    logic                  w_step;
    logic [TRY_W-1:0]      w_tries_nxt;
    logic [2:0]            w_piece_nxt;
    logic                  w_valid_nxt;
    logic [NUM_PIECES-1:0] w_bag_mask_nxt;
    logic [NUM_PIECES-1:0] w_bag_mask_issue;
    logic [2:0]            w_cand;
    logic                  w_cand_in_range;
    logic                  w_cand_ok;
    logic [2:0]            w_fallback;
    logic [2:0]            w_issue_id;
    logic                  w_draw_done;

    // ------------------------------------------------------------------
    // LFSR and frame tick
    // ------------------------------------------------------------------
    assign w_lfsr_step  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_frame_edge = frame_clk & ~r_frame_d;
    assign w_step       = (STEP_MODE == 0) ? 1'b1 : w_frame_edge;

    // Pick the next LFSR value. A seed load beats stepping, and a zero seed
    // is replaced by SEED. A zero register (lock-up) reloads SEED.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (seed_load) begin
            w_lfsr_nxt = (seed == '0) ? SEED : seed;
        end else if (r_lfsr == '0) begin
            w_lfsr_nxt = SEED;
        end else if (w_step) begin
            w_lfsr_nxt = w_lfsr_step;
        end
    end

    // Register the LFSR and the delayed frame tick used for edge detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr    <= SEED;
            r_frame_d <= 1'b0;
        end else begin
            r_lfsr    <= w_lfsr_nxt;
            r_frame_d <= frame_clk;
        end
    end

    // ------------------------------------------------------------------
    // Candidate evaluation
    // ------------------------------------------------------------------
    assign w_cand          = r_lfsr[2:0];
    assign w_cand_in_range = ({1'b0, w_cand} < NP4);

`ifdef PIECE_RANDOMIZER_BAG_EN
    logic                  w_cand_used;
    logic [2:0]            w_lowest_free;
    logic                  w_free_found;
    logic [NUM_PIECES-1:0] w_mask_set;

    // Flag a candidate that was already issued from the current bag
    always_comb begin
        w_cand_used = 1'b0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if ((w_cand == i[2:0]) && r_bag_mask[i]) begin
                w_cand_used = 1'b1;
            end
        end
    end

    // Find the lowest ID still unused in this bag, for the fallback
    always_comb begin
        w_lowest_free = 3'd0;
        w_free_found  = 1'b0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if (!w_free_found && !r_bag_mask[i]) begin
                w_lowest_free = i[2:0];
                w_free_found  = 1'b1;
            end
        end
    end

    // Add the issued ID to the bag. A full bag empties in the same update.
    always_comb begin
        w_mask_set = r_bag_mask;
        for (int i = 0; i < NUM_PIECES; i++) begin
            if (w_issue_id == i[2:0]) begin
                w_mask_set[i] = 1'b1;
            end
        end
        w_bag_mask_issue = (w_mask_set == FULL_MASK) ? '0 : w_mask_set;
    end

    assign w_cand_ok  = w_cand_in_range && !w_cand_used;
    assign w_fallback = w_lowest_free;
`else
    assign w_cand_ok        = w_cand_in_range;
    assign w_fallback       = 3'(int'(w_cand) % NUM_PIECES);
    assign w_bag_mask_issue = '0;
`endif

    // A draw ends on a good candidate or on the final allowed try
    assign w_draw_done = w_cand_ok || (r_tries == TRY_MAX);
    assign w_issue_id  = w_cand_ok ? w_cand : w_fallback;

    // ------------------------------------------------------------------
    // Draw / hold FSM
    // ------------------------------------------------------------------
    // Next-state and output logic: DRAW tests one candidate per cycle;
    // HOLD waits for the consumer to take the piece.
    always_comb begin
        w_state_nxt    = r_state;
        w_tries_nxt    = r_tries;
        w_piece_nxt    = r_piece;
        w_valid_nxt    = r_valid;
        w_bag_mask_nxt = r_bag_mask;
        case (r_state)
            S_DRAW: begin
                if (w_draw_done) begin
                    w_piece_nxt    = w_issue_id;
                    w_valid_nxt    = 1'b1;
                    w_bag_mask_nxt = w_bag_mask_issue;
                    w_tries_nxt    = '0;
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_tries_nxt = r_tries + 1'b1;
                end
            end
            S_HOLD: begin
                if (next_req) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_DRAW;
                end
            end
            default: begin
                w_state_nxt = S_DRAW;
            end
        endcase
    end

    // FSM state and delivered-piece registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_DRAW;
            r_tries    <= '0;
            r_piece    <= '0;
            r_valid    <= 1'b0;
            r_bag_mask <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tries    <= w_tries_nxt;
            r_piece    <= w_piece_nxt;
            r_valid    <= w_valid_nxt;
            r_bag_mask <= w_bag_mask_nxt;
        end
    end

    assign piece       = r_piece;
    assign piece_valid = r_valid;
    assign bag_mask    = r_bag_mask;
    assign o_dbg_state = r_state;
    assign o_dbg_lfsr  = r_lfsr;

endmodule

// File: tb/tb_piece_randomizer.sv
// tb_piece_randomizer
// Two instances share clock and stimulus. dut0 uses STEP_MODE=0 and dut1
// uses STEP_MODE=1; each has its own next_req. A behavioural model tracks
// both and predicts the outputs every cycle. Directed tables and sequences
// cover reset, fallback, seed handling, LFSR period and bag permutations.
module tb_piece_randomizer;

    localparam int          NP   = 7;
    localparam int          MT   = 15;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef PIECE_RANDOMIZER_BAG_EN
    localparam bit BAG = 1'b1;
`else
    localparam bit BAG = 1'b0;
`endif

    // ---------------- clock / reset / stimulus signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset     = 1'b1;
    logic          frame_clk = 1'b0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed      = 16'h0000;
    logic          next_req0 = 1'b0;
    logic          next_req1 = 1'b0;

    logic [2:0]    piece0, piece1;
    logic          valid0, valid1;
    logic [NP-1:0] mask0, mask1;
    logic          st0, st1;
    logic [15:0]   lfsr0, lfsr1;

    piece_randomizer #(.STEP_MODE(0)) dut0 (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .seed_load(seed_load),
        .seed(seed), .next_req(next_req0), .piece(piece0), .piece_valid(valid0),
        .bag_mask(mask0), .o_dbg_state(st0), .o_dbg_lfsr(lfsr0)
    );

    piece_randomizer #(.STEP_MODE(1)) dut1 (
        .Clk(clk), .Reset(reset), .frame_clk(frame_clk), .seed_load(seed_load),
        .seed(seed), .next_req(next_req1), .piece(piece1), .piece_valid(valid1),
        .bag_mask(mask1), .o_dbg_state(st1), .o_dbg_lfsr(lfsr1)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    bit lockstep_en = 1'b0;
    logic [2:0] exp_q[$];   // IDs the model issued on dut0

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [15:0] m_lfsr[2];
    logic        m_fd;
    logic        m_valid[2];
    logic [2:0]  m_piece[2];
    logic [7:0]  m_used[2];
    bit          m_drawing[2];
    int          m_age[2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int lowest_unused(input logic [7:0] used);
        for (int i = 0; i < NP; i++) begin
            if (!used[i]) return i;
        end
        return 0;
    endfunction

    // One cycle of piece bookkeeping for instance k, using the LFSR value
    // held during this cycle.
    function automatic void model_draw(input int k, input logic req);
        int cand;
        int pick;
        bit ok;
        if (m_drawing[k]) begin
            cand = int'(m_lfsr[k][2:0]);
            ok   = (cand < NP) && !(BAG && m_used[k][cand]);
            pick = -1;
            if (ok) pick = cand;
            else if (m_age[k] == MT) pick = BAG ? lowest_unused(m_used[k]) : (cand % NP);
            else m_age[k]++;
            if (pick >= 0) begin
                m_piece[k]   = pick[2:0];
                m_valid[k]   = 1'b1;
                m_drawing[k] = 1'b0;
                m_age[k]     = 0;
                if (BAG) begin
                    m_used[k][pick] = 1'b1;
                    if ($countones(m_used[k]) == NP) m_used[k] = 8'h00;
                end
                if (k == 0) exp_q.push_back(pick[2:0]);
            end
        end else if (req) begin
            m_valid[k]   = 1'b0;
            m_drawing[k] = 1'b1;
            m_age[k]     = 0;
        end
    endfunction

    always @(posedge clk) begin
        bit rise;
        rise = frame_clk && !m_fd;
        if (reset) begin
            m_fd = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_lfsr[k] = SEED; m_valid[k] = 1'b0; m_piece[k] = 3'd0;
                m_used[k] = 8'h00; m_drawing[k] = 1'b1; m_age[k] = 0;
            end
        end else begin
            m_fd = frame_clk;
            for (int k = 0; k < 2; k++) begin
                model_draw(k, (k == 0) ? next_req0 : next_req1);
                if (seed_load) m_lfsr[k] = (seed == 16'h0000) ? SEED : seed;
                else if (k == 0 || rise) m_lfsr[k] = lfsr_next(m_lfsr[k]);
            end
        end
    end

    // ---------------- driver: one clock, then sample and compare ----------------
    task automatic step();
        logic [31:0] act, exp;
        @(posedge clk);
        #1;
        if (lockstep_en) begin
            act = {4'd0, lfsr0, 1'b0, mask0, piece0, valid0};
            exp = {4'd0, m_lfsr[0], m_used[0], m_piece[0], m_valid[0]};
            check("lockstep_dut0", act, exp);
            act = {4'd0, lfsr1, 1'b0, mask1, piece1, valid1};
            exp = {4'd0, m_lfsr[1], m_used[1], m_piece[1], m_valid[1]};
            check("lockstep_dut1", act, exp);
        end
    endtask

    task automatic handshake0(output logic [2:0] p, output logic [7:0] m);
        int n;
        n = 0;
        while (!valid0 && n < MT + 2) begin
            step();
            n++;
        end
        check("hs_latency_ok", 32'(valid0 && (n <= MT + 1)), 32'd1);
        p = piece0;
        m = {1'b0, mask0};
        if (exp_q.size() > 0) check("hs_piece", 32'(piece0), 32'(exp_q.pop_front()));
        else check("hs_piece_missing", 32'(exp_q.size()), 32'd1);
        next_req0 = 1'b1;
        step();
        next_req0 = 1'b0;
        check("hs_valid_drop", 32'(valid0), 32'd0);
    endtask

    // ---------------- directed vector table (dut1, STEP_MODE=1) ----------------
    typedef struct {
        logic        rst;
        logic        sl;
        logic [15:0] sd;
        logic        nr;
        logic        fc;
        logic        ev;
        logic [2:0]  ep;
        logic [7:0]  em;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic sl, input logic [15:0] sd,
                                input logic nr, input logic fc, input logic ev,
                                input logic [2:0] ep, input logic [7:0] em);
        vec_t v;
        v.rst = rst; v.sl = sl; v.sd = sd; v.nr = nr; v.fc = fc;
        v.ev = ev; v.ep = ep; v.em = em;
        return v;
    endfunction

    initial begin
        vec_t        vt[14];
        logic [7:0]  m1, m13, grp, seen, expm, m;
        logic [2:0]  p;
        bit          grp_ok;
        int          n, errs, ret;

        m1  = BAG ? 8'h02 : 8'h00;
        m13 = BAG ? 8'h0A : 8'h00;
        //          rst  sl    seed      nr   fc   valid piece mask
        vt[0]  = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        vt[1]  = mk(1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        vt[2]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, m1);
        vt[3]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, m1);
        vt[4]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 3'd1, m1);
        vt[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd1, m1);
        vt[6]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, m13);
        vt[7]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
        vt[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, m1);
        vt[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd1, m1);
        vt[10] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        vt[11] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, m1);
        vt[12] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, m1);
        vt[13] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd1, m1);

        lockstep_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            reset = vt[i].rst; seed_load = vt[i].sl; seed = vt[i].sd;
            next_req1 = vt[i].nr; frame_clk = vt[i].fc; next_req0 = 1'b0;
            step();
            check($sformatf("vec%0d_valid", i), 32'(valid1), 32'(vt[i].ev));
            check($sformatf("vec%0d_piece", i), 32'(piece1), 32'(vt[i].ep));
            check($sformatf("vec%0d_mask", i), 32'({1'b0, mask1}), 32'(vt[i].em));
        end
        reset = 1'b0; seed_load = 1'b0; next_req1 = 1'b0; frame_clk = 1'b0;

        // Fallback: seed 7 gives candidate 7 with no frame edges, so every try fails
        seed_load = 1'b1; seed = 16'h0007;
        step();
        seed_load = 1'b0;
        check("seed7_lfsr", 32'(lfsr1), 32'h0007);
        next_req1 = 1'b1;
        step();
        next_req1 = 1'b0;
        check("fb_valid_drop", 32'(valid1), 32'd0);
        n = 0;
        while (!valid1 && n < 40) begin
            step();
            n++;
        end
        check("fb_latency", 32'(n), 32'(MT + 1));
        check("fb_piece", 32'(piece1), 32'd0);
        check("fb_mask", 32'({1'b0, mask1}), BAG ? 32'h03 : 32'h00);

        // Reset in the middle of a long draw
        seed_load = 1'b1; seed = 16'h0007;
        step();
        seed_load = 1'b0; next_req1 = 1'b1;
        step();
        next_req1 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("middraw_still_busy", 32'(valid1), 32'd0);
        reset = 1'b1;
        step();
        check("middraw_rst_outs", 32'({valid1, piece1, 1'b0, mask1}), 32'd0);
        check("middraw_rst_lfsr", 32'(lfsr1), 32'(SEED));
        reset = 1'b0;
        step();
        check("middraw_release_piece", 32'({valid1, piece1}), 32'h9);

        // Zero seed reloads SEED; then walk the full period on dut0
        for (int i = 0; i < 3; i++) step();
        seed_load = 1'b1; seed = 16'h0000;
        step();
        seed_load = 1'b0;
        check("seed0_lfsr_dut0", 32'(lfsr0), 32'(SEED));
        check("seed0_lfsr_dut1", 32'(lfsr1), 32'(SEED));
        lockstep_en = 1'b0;
        errs = 0; ret = 0;
        for (int i = 1; i <= 65536; i++) begin
            step();
            if (lfsr0 == 16'h0000 || lfsr0 !== m_lfsr[0]) errs++;
            if (ret == 0 && lfsr0 == SEED) ret = i;
        end
        check("lfsr_walk_errors", 32'(errs), 32'd0);
        check("lfsr_period", 32'(ret), 32'd65535);
        lockstep_en = 1'b1;

        // Fourteen handshakes on dut0 (STEP_MODE=0): two bags' worth
        reset = 1'b1;
        step();
        exp_q.delete();
        reset = 1'b0;
        grp = 8'h00;
        for (int g = 0; g < 2; g++) begin
            seen = 8'h00; grp_ok = 1'b1;
            for (int j = 0; j < NP; j++) begin
                handshake0(p, m);
                grp_ok = grp_ok && (p < NP) && (!BAG || !seen[p]);
                seen[p] = 1'b1;
                grp = grp | (8'd1 << p);
                expm = ($countones(grp) == NP) ? 8'h00 : grp;
                if ($countones(grp) == NP) grp = 8'h00;
                check($sformatf("hs%0d_mask", g * NP + j), 32'(m), BAG ? 32'(expm) : 32'd0);
            end
            check($sformatf("hs_group%0d", g), 32'(grp_ok), 32'd1);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            frame_clk = ($urandom_range(0, 3) == 0);
            next_req0 = $urandom_range(0, 1) == 1;
            next_req1 = $urandom_range(0, 1) == 1;
            seed_load = ($urandom_range(0, 63) == 0);
            seed      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            reset     = ($urandom_range(0, 255) == 0);
            step();
        end
        reset = 1'b0; seed_load = 1'b0; next_req0 = 1'b0; next_req1 = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
